usb_upstream_arbiter: RTL
=========================

// Module: usb_upstream_arbiter
// PURPOSE
//  Round-robin packet arbiter draining NPORTS downstream-port FIFOs (registered-read fifo, 1-cycle read latency) onto the single upstream TX stream of the hub.
//  Grant is held per packet (until a beat with the LAST bit), never per beat; inter-packet gap enforced; runaway packets cut by a beat-count watchdog.
// PARAMETERS
//  NPORTS     4   number of downstream FIFOs (2..8)
//  WIDTH      8   payload bits per beat; FIFO word is WIDTH+1, bit [WIDTH] = LAST
//  IPG        2   idle cycles forced between packets (0..15)
//  MAX_BEATS  64  watchdog: beats per packet before forced termination
// PORTS
//  clk          in   1                clock, all logic on posedge
//  rst          in   1                asynchronous, active-high reset
//  fifo_empty   in   NPORTS           per-port flag_empty
//  fifo_rdata   in   NPORTS*(WIDTH+1) per-port r_data, port p at [p*(WIDTH+1)+:WIDTH+1]
//  fifo_rd_en   out  NPORTS           per-port rd_en, combinational, one-hot or zero
//  up_valid     out  1                upstream beat valid (registered)
//  up_data      out  WIDTH            upstream beat payload (registered)
//  up_last      out  1                final beat of packet (registered)
//  up_ready     in   1                upstream accepts beat when up_valid&&up_ready
//  grant_port   out  $clog2(NPORTS)   port currently granted (registered)
//  busy         out  1                high in every state except IDLE
//  wdog_err     out  1                one-cycle pulse when watchdog truncates a packet
// BEHAVIOUR
//  Reset: state=IDLE, fifo_rd_en=0, up_valid=0, up_data=0, up_last=0, grant_port=0, busy=0, wdog_err=0, rr_ptr=0, pending=0, beat_cnt=0, gap_cnt=0.
//  Reset mid-packet aborts immediately; no partial beat is presented afterwards; FIFO contents are not touched.
//  States: IDLE -> XFER -> DRAIN -> GAP -> IDLE.
//  IDLE: pick first port with !fifo_empty scanning rr_ptr, rr_ptr+1, ... mod NPORTS; if found, latch grant_port, assert its fifo_rd_en in the same cycle, pending<=1, beat_cnt<=0, go XFER. None found: stay.
//  pending = one read outstanding; the word is valid on fifo_rdata[grant_port] from the cycle after rd_en and holds until the next rd_en.
//  load = pending && (!up_valid || up_ready). On load: up_data/up_last <= word, up_valid<=1, pending<=0, beat_cnt++.
//  XFER rd_en (granted port only) = (!pending || load) && !fifo_empty[g] && !(pending && word.LAST) && !last_loaded; gives 1 beat/cycle with up_ready=1.
//  Granted FIFO empty mid-packet: wait in XFER (no timeout other than watchdog); up_valid drops after the current beat drains.
//  Beat with LAST loaded -> go DRAIN; no further reads from that port.
//  Watchdog: load of beat number MAX_BEATS without LAST forces up_last=1 on that beat, pulses wdog_err, goes DRAIN; remaining beats of the packet stay in the FIFO and form the next packet from that port.
//  DRAIN: wait for up_valid&&up_ready on the last beat; then up_valid<=0, rr_ptr<=grant_port+1 mod NPORTS, gap_cnt<=IPG, go GAP (IPG=0: straight to IDLE).
//  GAP: gap_cnt decrements each cycle; exits to IDLE when it reaches 1; no rd_en, up_valid=0.
//  up_valid, once high, stays high with stable up_data/up_last until up_ready (AXI-style); never asserted in IDLE/GAP.
//  beat_cnt width $clog2(MAX_BEATS+1), saturating; rr_ptr wraps NPORTS-1 -> 0.
//  fifo_rd_en never asserted to a port whose fifo_empty=1, never to a non-granted port.
// TESTING
//  1 single port 0 packet {A1,A2,A3+LAST}, up_ready=1 -> up beats A1,A2,A3 on consecutive cycles, up_last on A3, busy low IPG+1 cycles later.
//  2 ports 1,2,3 each hold one 2-beat packet, rr_ptr=0 -> grant order 1,2,3; exactly IPG idle cycles between packets; then port 0 wins after refill.
//  3 backpressure: up_ready toggles 1,0,0,1,... during 4-beat packet -> no beat lost or duplicated, up_data stable while up_valid&&!up_ready, rd_en count = 4.
//  4 port FIFO runs empty after beat 2 of 4, refill after 5 cycles -> grant held, up_valid low during gap, packet completes intact, no other port granted.
//  5 MAX_BEATS=4, port 0 packet of 6 beats -> beat 4 with up_last=1 and wdog_err pulse; beats 5,6 sent later as separate packet.
//  6 assert rst during beat 2 of a packet -> all outputs at reset values next edge; after release the arbiter starts at port 0 scan and FIFO state is untouched.

Source files
------------

// File: rtl/usb_upstream_arbiter.sv
// Round-robin packet arbiter: drains NPORTS registered-read FIFOs onto one
// upstream TX beat stream. Grant is held for a whole packet, an idle gap is
// forced between packets, and a beat-count watchdog truncates runaway packets.
module usb_upstream_arbiter #(
  parameter int NPORTS    = 4,
  parameter int WIDTH     = 8,
  parameter int IPG       = 2,
  parameter int MAX_BEATS = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORTS-1:0]           fifo_empty,
  input  logic [NPORTS*(WIDTH+1)-1:0] fifo_rdata,
  output logic [NPORTS-1:0]           fifo_rd_en,
  output logic                        up_valid,
  output logic [WIDTH-1:0]            up_data,
  output logic                        up_last,
  input  logic                        up_ready,
  output logic [$clog2(NPORTS)-1:0]   grant_port,
  output logic                        busy,
  output logic                        wdog_err
);

  localparam int GW = $clog2(NPORTS);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int DW = WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              pending_q, pending_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              up_valid_q, up_valid_d;
  logic [WIDTH-1:0]  up_data_q, up_data_d;
  logic              up_last_q, up_last_d;
  logic              wdog_q, wdog_d;
  logic [NPORTS-1:0] rd_en;

  logic [DW-1:0]     words [NPORTS];
  logic [DW-1:0]     word;
  logic              load;
  logic              wd_hit;
  logic              scan_found;
  logic [GW-1:0]     scan_port;
  logic [GW:0]       scan_idx;
  logic [GW-1:0]     next_ptr;

  // Split the flat read-data bus into one word per port.
  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_words
    assign words[gi] = fifo_rdata[gi*DW +: DW];
  end

  assign word     = words[grant_q];
  // The outstanding word moves into the output register whenever it is free.
  assign load     = pending_q && (!up_valid_q || up_ready);
  // Beat MAX_BEATS arriving without LAST is forced to end the packet.
  assign wd_hit   = load && !word[WIDTH] && (beat_cnt_q == BW'(MAX_BEATS - 1));
  assign next_ptr = (grant_q == GW'(NPORTS - 1)) ? '0 : grant_q + 1'b1;

  // Round-robin scan starting at rr_ptr; lowest offset wins, so iterate downward.
  always_comb begin
    scan_found = 1'b0;
    scan_port  = '0;
    scan_idx   = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      scan_idx = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (scan_idx >= (GW+1)'(NPORTS)) scan_idx = scan_idx - (GW+1)'(NPORTS);
      if (!fifo_empty[scan_idx[GW-1:0]]) begin
        scan_found = 1'b1;
        scan_port  = scan_idx[GW-1:0];
      end
    end
  end

  // Next-state, datapath and FIFO read-enable logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    pending_d  = pending_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    up_valid_d = up_valid_q;
    up_data_d  = up_data_q;
    up_last_d  = up_last_q;
    wdog_d     = 1'b0;
    rd_en      = '0;

    // An accepted beat frees the output register unless refilled below.
    if (up_valid_q && up_ready) up_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (scan_found) begin
          grant_d          = scan_port;
          rd_en[scan_port] = 1'b1;
          pending_d        = 1'b1;
          beat_cnt_d       = '0;
          state_d          = S_XFER;
        end
      end
      S_XFER: begin
        if (load) begin
          up_data_d  = word[WIDTH-1:0];
          up_last_d  = word[WIDTH] | wd_hit;
          up_valid_d = 1'b1;
          pending_d  = 1'b0;
          wdog_d     = wd_hit;
          if (beat_cnt_q != BW'(MAX_BEATS)) beat_cnt_d = beat_cnt_q + 1'b1;
          if (word[WIDTH] || wd_hit) state_d = S_DRAIN;
        end
        // Keep one read in flight; stop once the closing beat is known.
        if ((!pending_q || load) && !fifo_empty[grant_q] &&
            !(pending_q && word[WIDTH]) && !wd_hit) begin
          rd_en[grant_q] = 1'b1;
          pending_d      = 1'b1;
        end
      end
      S_DRAIN: begin
        if (up_valid_q && up_ready) begin
          rr_ptr_d  = next_ptr;
          gap_cnt_d = 4'(IPG);
          state_d   = (IPG == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q <= 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      pending_q  <= 1'b0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      up_valid_q <= 1'b0;
      up_data_q  <= '0;
      up_last_q  <= 1'b0;
      wdog_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      pending_q  <= pending_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      up_valid_q <= up_valid_d;
      up_data_q  <= up_data_d;
      up_last_q  <= up_last_d;
      wdog_q     <= wdog_d;
    end
  end

  // Reads are suppressed while reset is held so FIFO contents survive it.
  assign fifo_rd_en = rst ? '0 : rd_en;
  assign up_valid   = up_valid_q;
  assign up_data    = up_data_q;
  assign up_last    = up_last_q;
  assign grant_port = grant_q;
  assign busy       = (state_q != S_IDLE);
  assign wdog_err   = wdog_q;

endmodule
